// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, jump flush, load-use
// stall, operand forwarding and saturating stall/flush performance counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memRead,
  input  logic        ex_regW,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regW,
  input  logic        mem_memRead,
  input  logic        mem_memWrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regW,
  input  logic        jump_taken,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exme_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exme_flush,
  output logic        memwb_flush,
  output logic        pc_sel,
  output logic        dmem_req,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic        bus_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERR} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic w_mem_acc;
  logic w_mstall;
  logic w_jump_flush;
  logic w_load_use;
  logic w_unused;

  // A load always writes its destination, so the EX write flag adds nothing here.
  assign w_unused  = ex_regW;
  assign w_mem_acc = mem_memRead | mem_memWrite;
  assign dmem_req  = ((r_state == ST_RUN) & w_mem_acc) | (r_state == ST_MEM_WAIT);
  assign w_mstall  = dmem_req & ~dmem_ack;
  assign w_jump_flush = (r_state != ST_ERR) & ~w_mstall & jump_taken;
  assign w_load_use = ex_memRead & (ex_rd != 5'd0) &
                      ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

  assign bus_err   = (r_state == ST_ERR);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mstall) w_state_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (dmem_ack)                 w_state_next = ST_RUN;
        else if (r_wait_cnt == 8'd254) w_state_next = ST_ERR;
      end
      ST_ERR:  w_state_next = ST_ERR;
      default: w_state_next = ST_RUN;
    endcase
  end

  // Priority: error > memory stall > jump > load-use.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exme_en     = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exme_flush  = 1'b0;
    memwb_flush = 1'b0;
    pc_sel      = 1'b0;
    if (r_state == ST_ERR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exme_en  = 1'b0;
      memwb_en = 1'b0;
    end else if (w_mstall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exme_en     = 1'b0;
      memwb_flush = 1'b1;
    end else if (jump_taken) begin
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exme_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (mem_regW && (mem_rd != 5'd0) && (mem_rd == ex_rs1))     fwdA = 2'b10;
    else if (wb_regW && (wb_rd != 5'd0) && (wb_rd == ex_rs1))   fwdA = 2'b01;
    if (mem_regW && (mem_rd != 5'd0) && (mem_rd == ex_rs2))     fwdB = 2'b10;
    else if (wb_regW && (wb_rd != 5'd0) && (wb_rd == ex_rs2))   fwdB = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_RUN) && w_mstall)
        r_wait_cnt <= 8'd0;
      else if ((r_state == ST_MEM_WAIT) && !dmem_ack)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (!pc_en && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_jump_flush && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use1, id_use2;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_memRead, ex_regW;
  logic [4:0]  mem_rd;
  logic        mem_regW, mem_memRead, mem_memWrite;
  logic [4:0]  wb_rd;
  logic        wb_regW;
  logic        jump_taken, dmem_ack;
  logic        pc_en, ifid_en, idex_en, exme_en, memwb_en;
  logic        ifid_flush, idex_flush, exme_flush, memwb_flush;
  logic        pc_sel, dmem_req, bus_err;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: length of the current run of unacknowledged memory cycles,
  // sticky error, and the two event counts.
  int m_streak;
  bit m_err;
  int m_stall;
  int m_flush;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_regW(ex_regW),
    .mem_rd(mem_rd), .mem_regW(mem_regW), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .wb_rd(wb_rd), .wb_regW(wb_regW),
    .jump_taken(jump_taken), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exme_en(exme_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exme_flush(exme_flush), .memwb_flush(memwb_flush),
    .pc_sel(pc_sel), .dmem_req(dmem_req), .fwdA(fwdA), .fwdB(fwdB),
    .bus_err(bus_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memRead = 0; ex_regW = 0;
    mem_rd = 0; mem_regW = 0; mem_memRead = 0; mem_memWrite = 0;
    wb_rd = 0; wb_regW = 0; jump_taken = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m_streak = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (mem_regW && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regW && wb_rd != 0 && wb_rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  // Order: pc,ifid,idex,exme,memwb enables; ifid,idex,exme,memwb flushes; pc_sel, dmem_req, bus_err, fwdA, fwdB
  function automatic logic [15:0] model_ctrl(output bit stalled, output bit jumped);
    bit acc, req, mst, lu;
    logic [4:0] en;
    logic [3:0] fl;
    logic sel;
    acc = mem_memRead | mem_memWrite;
    req = m_err ? 1'b0 : ((m_streak > 0) ? 1'b1 : acc);
    mst = req && !dmem_ack;
    lu  = ex_memRead && ex_rd != 0 &&
          ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
    en = 5'b11111; fl = 4'b0000; sel = 1'b0; jumped = 0;
    if (m_err)           en = 5'b00000;
    else if (mst)        begin en = 5'b00001; fl = 4'b0001; end
    else if (jump_taken) begin sel = 1'b1; fl = 4'b1110; jumped = 1; end
    else if (lu)         begin en = 5'b00111; fl = 4'b0100; end
    stalled = !en[4];
    return {en, fl, sel, req, m_err, model_fwd(ex_rs1), model_fwd(ex_rs2)};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || bus_err !== 1'b0 || dmem_req !== 1'b0 || pc_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: stall=%0d flush=%0d bus_err=%b req=%b pc_en=%b expected 0 0 0 0 1",
               stall_cnt, flush_cnt, bus_err, dmem_req, pc_en);
    end
    rst = 1'b1;
    @(negedge clk);
    mem_memRead = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;   // asynchronous assertion mid-cycle
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || dmem_req !== 1'b1 || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: stall=%0d req=%b pc_en=%b expected 0 1 0", stall_cnt, dmem_req, pc_en);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ex_memRead = 1; ex_regW = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_en, exme_en, memwb_en, idex_flush, ifid_flush} !== 7'b0011110) begin
      failures++;
      $display("FAIL load_use_ctrl: en=%b%b%b%b%b idex_fl=%b ifid_fl=%b expected 00111 1 0",
               pc_en, ifid_en, idex_en, exme_en, memwb_en, idex_flush, ifid_flush);
    end
    @(negedge clk);
    clear_inputs();
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_use1 = 1;   // x0 never causes a hazard
    #1;
    checks++;
    if (pc_en !== 1'b1 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL load_use_after: pc_en=%b stall=%0d expected 1 1", pc_en, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_memRead = 1; dmem_ack = 0;
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_en, exme_en, memwb_flush, dmem_req, ifid_flush} !== 7'b0000110) begin
        failures++;
        $display("FAIL mem_wait_cycle%0d: pc/ifid/idex/exme=%b%b%b%b mwb_fl=%b req=%b ifid_fl=%b expected 0000 1 1 0",
                 i, pc_en, ifid_en, idex_en, exme_en, memwb_flush, dmem_req, ifid_flush);
      end
    end
    @(negedge clk);
    dmem_ack = 1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || dmem_req !== 1'b1 || memwb_flush !== 1'b0) begin
      failures++;
      $display("FAIL mem_wait_ack: pc_en=%b req=%b mwb_fl=%b expected 1 1 0", pc_en, dmem_req, memwb_flush);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL mem_wait_done: req=%b stall=%0d expected 0 3", dmem_req, stall_cnt);
    end
  endtask

  task automatic test_jump();
    do_reset();
    @(negedge clk);
    ex_memRead = 1; ex_rd = 9; id_rs2 = 9; id_use2 = 1; jump_taken = 1;
    #1;
    checks++;
    if ({pc_sel, ifid_flush, idex_flush, exme_flush, memwb_flush, pc_en, ifid_en, memwb_en} !== 8'b11110111) begin
      failures++;
      $display("FAIL jump_ctrl: sel=%b fl=%b%b%b%b pc/ifid/mwb_en=%b%b%b expected 1 1110 111",
               pc_sel, ifid_flush, idex_flush, exme_flush, memwb_flush, pc_en, ifid_en, memwb_en);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0 || pc_sel !== 1'b0) begin
      failures++;
      $display("FAIL jump_after: flush=%0d stall=%0d sel=%b expected 1 0 0", flush_cnt, stall_cnt, pc_sel);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regW = 1; wb_regW = 1; ex_rs2 = 0;
    #1;
    checks++;
    if (fwdA !== 2'b10 || fwdB !== 2'b00) begin
      failures++;
      $display("FAIL fwd_mem_priority: fwdA=%b fwdB=%b expected 10 00", fwdA, fwdB);
    end
    mem_regW = 0; ex_rs2 = 7;
    #1;
    checks++;
    if (fwdA !== 2'b01 || fwdB !== 2'b01) begin
      failures++;
      $display("FAIL fwd_wb: fwdA=%b fwdB=%b expected 01 01", fwdA, fwdB);
    end
    mem_rd = 0; wb_rd = 0; mem_regW = 1; ex_rs1 = 0; ex_rs2 = 0;
    #1;
    checks++;
    if (fwdA !== 2'b00 || fwdB !== 2'b00) begin
      failures++;
      $display("FAIL fwd_x0: fwdA=%b fwdB=%b expected 00 00", fwdA, fwdB);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_v, got_v;
    bit st, jp;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_use1 = 1'($urandom); id_use2 = 1'($urandom);
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3)); ex_rd = 5'($urandom_range(0, 3));
      ex_memRead = 1'($urandom); ex_regW = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_regW = 1'($urandom);
      mem_memRead = ($urandom_range(0, 3) == 0); mem_memWrite = ($urandom_range(0, 6) == 0);
      wb_rd = 5'($urandom_range(0, 3)); wb_regW = 1'($urandom);
      jump_taken = ($urandom_range(0, 6) == 0);
      dmem_ack = ($urandom_range(0, 4) < 3);
      #1;
      exp_v = model_ctrl(st, jp);
      got_v = {pc_en, ifid_en, idex_en, exme_en, memwb_en, ifid_flush, idex_flush, exme_flush,
               memwb_flush, pc_sel, dmem_req, bus_err, fwdA, fwdB};
      checks++;
      if (got_v !== exp_v || stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
        failures++;
        $display("FAIL random_cyc%0d: ctrl=%b stall=%0d flush=%0d expected ctrl=%b stall=%0d flush=%0d",
                 cyc, got_v, stall_cnt, flush_cnt, exp_v, m_stall, m_flush);
      end
      // advance the model across the coming rising edge
      if (!m_err) begin
        if (exp_v[5] && !dmem_ack) m_streak++;
        else                       m_streak = 0;
        if (m_streak >= 256) m_err = 1;
      end
      if (st && m_stall < 65535) m_stall++;
      if (jp && m_flush < 65535) m_flush++;
    end
  endtask

  task automatic test_timeout();
    int early_err;
    do_reset();
    early_err = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      mem_memWrite = 1; dmem_ack = 0;
      #1;
      if (bus_err !== 1'b0 || dmem_req !== 1'b1) early_err++;
    end
    checks++;
    if (early_err != 0) begin
      failures++;
      $display("FAIL timeout_early: cycles_with_err_or_no_req=%0d expected 0", early_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus_err !== 1'b1 || dmem_req !== 1'b0 || pc_en !== 1'b0 || memwb_en !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: bus_err=%b req=%b pc_en=%b mwb_en=%b expected 1 0 0 0",
               bus_err, dmem_req, pc_en, memwb_en);
    end
    @(negedge clk);
    clear_inputs();
    dmem_ack = 1; jump_taken = 1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus_err !== 1'b1 || pc_sel !== 1'b0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL timeout_sticky: bus_err=%b sel=%b flush=%0d expected 1 0 0", bus_err, pc_sel, flush_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: bus_err=%b expected 0", bus_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk);
    mem_memRead = 1; dmem_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    mem_memRead = 0;
    rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || pc_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_stall: req=%b pc_en=%b expected 0 1", dmem_req, pc_en);
    end
    @(negedge clk);
    mem_memRead = 1; dmem_ack = 1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || pc_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_then_ack: req=%b pc_en=%b expected 1 1", dmem_req, pc_en);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    ex_memRead = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1;
    repeat (65540) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_saturate: stall=%h expected ffff", stall_cnt);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF || pc_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: stall=%h pc_en=%b expected ffff 0", stall_cnt, pc_en);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_jump();
    test_forwarding();
    test_random();
    test_timeout();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 id_use1, id_use2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-005 ex_rs1, ex_rs2, ex_rd  in  5 each  register fields of the instruction in EX.
REQ-006 ex_memRead, ex_regW  in  1 each  EX-stage load flag and register-write flag.
REQ-007 mem_rd  in  5; mem_regW, mem_memRead, mem_memWrite  in  1 each  MEM-stage fields taken from the EX/MEM register outputs.
REQ-008 wb_rd  in  5; wb_regW  in  1  WB-stage destination register and write flag.
REQ-009 jump_taken  in  1  branch/jump resolved taken in MEM.
REQ-010 dmem_ack  in  1  data memory completes the current access this cycle.
REQ-011 pc_en, ifid_en, idex_en, exme_en, memwb_en  out  1 each  pipeline register load enables.
REQ-012 ifid_flush, idex_flush, exme_flush, memwb_flush  out  1 each  load a bubble (all-zero control) instead of data.
REQ-013 pc_sel  out  1  1 = PC loads the jump target.
REQ-014 dmem_req  out  1  data memory access request.
REQ-015 fwdA, fwdB  out  2 each  EX operand select: 00 register file, 10 MEM ALU result, 01 WB result.
REQ-016 bus_err  out  1  sticky memory-timeout error flag.
REQ-017 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-018 The FSM SHALL have three states: RUN, MEM_WAIT and ERR.
REQ-019 mem_acc SHALL be defined as mem_memRead OR mem_memWrite.
REQ-020 dmem_req SHALL be 1 in RUN when mem_acc=1, 1 in MEM_WAIT, and 0 in ERR.
REQ-021 mstall SHALL be 1 when dmem_req=1 and dmem_ack=0.
REQ-022 Transition RUN->MEM_WAIT SHALL occur when mstall=1; an ack in the same cycle as the request SHALL cause no stall and no state change.
REQ-023 Transition MEM_WAIT->RUN SHALL occur on the cycle dmem_ack=1.
REQ-024 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack; reaching 255 SHALL force transition to ERR.
REQ-025 In ERR, bus_err SHALL be 1, all enables SHALL be 0, and the FSM SHALL leave ERR only on reset.
REQ-026 Mem stall: while mstall=1, pc_en, ifid_en, idex_en and exme_en SHALL be 0, memwb_flush SHALL be 1, and all other flushes SHALL be 0.
REQ-027 Jump (mstall=0, jump_taken=1): pc_sel=1; ifid_flush, idex_flush and exme_flush SHALL be 1 for exactly one cycle; all enables SHALL be 1.
REQ-028 Load-use: when mstall=0, jump_taken=0, ex_memRead=1, ex_rd!=0, and (id_use1 with id_rs1==ex_rd, or id_use2 with id_rs2==ex_rd), then pc_en=0, ifid_en=0, idex_flush=1, and the remaining enables SHALL be 1.
REQ-029 Priority SHALL be ERR > mem stall > jump > load-use; a lower-priority event masked in a cycle is re-evaluated the next cycle, because the frozen stages hold it.
REQ-030 With no event active, all enables SHALL be 1, all flushes 0 and pc_sel 0.
REQ-031 fwdA SHALL be 10 if mem_regW=1, mem_rd!=0 and mem_rd==ex_rs1; else 01 if wb_regW=1, wb_rd!=0 and wb_rd==ex_rs1; else 00. fwdB SHALL follow the same rule using ex_rs2. The MEM match takes precedence.
REQ-032 Control outputs and forwarding selects SHALL be combinational from the current inputs and state, with zero latency.
REQ-033 stall_cnt SHALL increment once per cycle with pc_en=0, saturating at 0xFFFF.
REQ-034 flush_cnt SHALL increment once per jump flush cycle, saturating at 0xFFFF.

Reset
REQ-035 On rst=0, asynchronously: state=RUN, wait counter=0, bus_err=0, stall_cnt=0, flush_cnt=0.
REQ-036 Reset mid-stall SHALL abandon the access; after reset release, dmem_req reflects only mem_acc.

Verification
REQ-037 Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_use1=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt increments by 1.
REQ-038 Mem wait: mem_memRead=1, dmem_ack=0 for 3 cycles then 1 -> pc_en/ifid_en/idex_en/exme_en=0 for 3 cycles; RUN is restored on the ack cycle; stall_cnt=3.
REQ-039 Jump coinciding with a load-use hazard: jump_taken=1 -> pc_sel=1; ifid/idex/exme flush=1; pc_en=1; flush_cnt=1; no stall.
REQ-040 Forwarding: mem_rd=wb_rd=ex_rs1=7, both write flags=1 -> fwdA=10; with ex_rs2=0 matched against rd=0 -> fwdB=00.
REQ-041 Timeout: mem_memWrite=1 and dmem_ack held 0 -> ERR after 255 wait cycles; bus_err=1; bus_err remains 1 until rst=0.
REQ-042 Counter saturation: stall_cnt preloaded at 0xFFFF through a long stall -> stays 0xFFFF.
